// File: rtl/store_data_align_pkg.sv
// Shared types and constants for the rv32i store data alignment path.
package store_data_align_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned STRB_W = XLEN / 8;

    typedef logic [XLEN-1:0]   word_st;
    typedef logic [STRB_W-1:0] strb_t;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } store_state_e;

endpackage

// File: rtl/store_data_align_lane_shift.sv
// Positions store data and byte strobes across two consecutive memory words.
module store_lane_shift
    import store_data_align_pkg::*;
(
    input  logic [1:0]  off_i,
    input  word_st      data_i,
    input  logic [2:0]  funct3_i,
    output logic [63:0] d64_c,
    output logic [7:0]  s8_c,
    output logic        legal_c,
    output logic        crosses_c
);

    logic [3:0] mask;
    word_st     data_masked;

    always_comb begin
        mask    = 4'b0000;
        legal_c = 1'b1;
        unique case (funct3_i)
            F3_SB:   mask = 4'b0001;
            F3_SH:   mask = 4'b0011;
            F3_SW:   mask = 4'b1111;
            default: legal_c = 1'b0;
        endcase

        // Bytes above the access size must not leak into neighbouring lanes.
        data_masked = data_i & {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
        s8_c        = 8'(mask) << off_i;
        d64_c       = 64'(data_masked) << {off_i, 3'b000};
        crosses_c   = |s8_c[7:4];
    end

endmodule

// File: rtl/store_data_align.sv
// Turns one store request into one or two word-aligned write beats with byte strobes.
module store_data_align
    import store_data_align_pkg::*;
#(
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  word_st            req_data_i,
    input  logic [2:0]        req_funct3_i,
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output word_st            mem_wdata_o,
    output strb_t             mem_strb_o,
    output logic              done_o,
    output logic              err_o
);

    store_state_e      state_q, state_d;
    logic              ready_q, ready_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d, hi_addr_q, hi_addr_d;
    word_st            wdata_q, wdata_d, hi_wdata_q, hi_wdata_d;
    strb_t             strb_q, strb_d, hi_strb_q, hi_strb_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [63:0] d64;
    logic [7:0]  s8;
    logic        legal;
    logic        crosses;

    // Evaluated on the incoming request so both beats are captured at acceptance.
    store_lane_shift u_lane_shift (
        .off_i     (req_addr_i[1:0]),
        .data_i    (req_data_i),
        .funct3_i  (req_funct3_i),
        .d64_c     (d64),
        .s8_c      (s8),
        .legal_c   (legal),
        .crosses_c (crosses)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            ready_q    <= 1'b0;
            valid_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            strb_q     <= '0;
            hi_addr_q  <= '0;
            hi_wdata_q <= '0;
            hi_strb_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            valid_q    <= valid_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            strb_q     <= strb_d;
            hi_addr_q  <= hi_addr_d;
            hi_wdata_q <= hi_wdata_d;
            hi_strb_q  <= hi_strb_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ready_d    = ready_q;
        valid_d    = valid_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;
        hi_addr_d  = hi_addr_q;
        hi_wdata_d = hi_wdata_q;
        hi_strb_d  = hi_strb_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (req_valid_i && ready_q) begin
                    if (!legal || (crosses && !SPLIT_MISALIGNED)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d    = BEAT0;
                        ready_d    = 1'b0;
                        valid_d    = 1'b1;
                        addr_d     = {req_addr_i[ADDR_W-1:2], 2'b00};
                        wdata_d    = d64[31:0];
                        strb_d     = s8[3:0];
                        hi_addr_d  = {req_addr_i[ADDR_W-1:2] + 30'd1, 2'b00};
                        hi_wdata_d = d64[63:32];
                        hi_strb_d  = s8[7:4];
                    end
                end
            end
            BEAT0: begin
                if (mem_ready_i) begin
                    if (hi_strb_q != '0) begin
                        state_d = BEAT1;
                        addr_d  = hi_addr_q;
                        wdata_d = hi_wdata_q;
                        strb_d  = hi_strb_q;
                    end else begin
                        state_d = IDLE;
                        ready_d = 1'b1;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        addr_d  = '0;
                        wdata_d = '0;
                        strb_d  = '0;
                    end
                end
            end
            BEAT1: begin
                if (mem_ready_i) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    addr_d  = '0;
                    wdata_d = '0;
                    strb_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    assign req_ready_o = ready_q;
    assign mem_valid_o = valid_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_strb_o  = strb_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_store_data_align.sv
// Scoreboard bench for store_data_align: byte-level reference model, random and directed stores.
module tb_store_data_align;
    import store_data_align_pkg::*;

    localparam int K_BEAT = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    word_st      req_data = '0;
    logic [2:0]  req_f3 = '0;
    logic        mem_valid;
    logic        mem_ready = 1'b1;
    logic [31:0] mem_addr;
    word_st      mem_wdata;
    strb_t       mem_strb;
    logic        done;
    logic        err;

    logic        ns_req_valid = 1'b0;
    logic        ns_req_ready;
    logic [31:0] ns_req_addr = '0;
    word_st      ns_req_data = '0;
    logic [2:0]  ns_req_f3 = '0;
    logic        ns_mem_valid;
    logic        ns_mem_ready = 1'b1;
    logic [31:0] ns_mem_addr;
    word_st      ns_mem_wdata;
    strb_t       ns_mem_strb;
    logic        ns_done;
    logic        ns_err;

    store_data_align #(.SPLIT_MISALIGNED(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_data_i(req_data), .req_funct3_i(req_f3),
        .mem_valid_o(mem_valid), .mem_ready_i(mem_ready),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_strb_o(mem_strb),
        .done_o(done), .err_o(err)
    );

    store_data_align #(.SPLIT_MISALIGNED(1'b0)) dut_ns (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(ns_req_valid), .req_ready_o(ns_req_ready),
        .req_addr_i(ns_req_addr), .req_data_i(ns_req_data), .req_funct3_i(ns_req_f3),
        .mem_valid_o(ns_mem_valid), .mem_ready_i(ns_mem_ready),
        .mem_addr_o(ns_mem_addr), .mem_wdata_o(ns_mem_wdata), .mem_strb_o(ns_mem_strb),
        .done_o(ns_done), .err_o(ns_err)
    );

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   ready_rand = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (ready_rand) mem_ready = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: walk the accessed bytes one by one and bin them into their memory words.
    function automatic void model(input logic [31:0] a, input logic [31:0] d,
                                  input logic [2:0] f3, input int acc_cyc, input bit timed);
        exp_t        b[2];
        int          nb;
        int          lane;
        logic [31:0] base;
        logic [31:0] ba;
        if (f3 > 3'd2) begin
            exp_q.push_back('{K_ERR, 32'h0, 4'h0, 32'h0, acc_cyc + 1});
            return;
        end
        base = a & 32'hFFFF_FFFC;
        b[0] = '{K_BEAT, base, 4'h0, 32'h0, -1};
        b[1] = '{K_BEAT, base + 32'd4, 4'h0, 32'h0, -1};
        nb = 1;
        for (int i = 0; i < (1 << f3); i++) begin
            ba   = a + 32'(i);
            lane = int'(ba[1:0]);
            if ((ba & 32'hFFFF_FFFC) != base) begin
                nb = 2;
                b[1].strb[lane]          = 1'b1;
                b[1].wdata[8*lane +: 8]  = d[8*i +: 8];
            end else begin
                b[0].strb[lane]          = 1'b1;
                b[0].wdata[8*lane +: 8]  = d[8*i +: 8];
            end
        end
        for (int j = 0; j < nb; j++) exp_q.push_back(b[j]);
        exp_q.push_back('{K_DONE, 32'h0, 4'h0, 32'h0, timed ? acc_cyc + 1 + nb : -1});
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                         input bit timed);
        int n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            chk("ready_timeout", 32'(req_ready), 32'd1);
            return;
        end
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_f3    = f3;
        model(a, d, f3, cyc, timed);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every observable DUT event.
    bit          prev_stall = 1'b0;
    logic [31:0] h_addr;
    logic [31:0] h_wdata;
    logic [3:0]  h_strb;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            chk("done_err_exclusive", 32'(done & err), 32'd0);
            if (mem_valid) begin
                if (prev_stall) begin
                    chk("hold_addr", mem_addr, h_addr);
                    chk("hold_wdata", mem_wdata, h_wdata);
                    chk("hold_strb", 32'(mem_strb), 32'(h_strb));
                end
                chk("beat_expected", (exp_q.size() == 0) ? 32'd99 : 32'(exp_q[0].kind), 32'(K_BEAT));
                if (mem_ready && exp_q.size() != 0 && exp_q[0].kind == K_BEAT) begin
                    e = exp_q.pop_front();
                    chk("beat_addr", mem_addr, e.addr);
                    chk("beat_strb", 32'(mem_strb), 32'(e.strb));
                    chk("beat_wdata", mem_wdata, e.wdata);
                end
                prev_stall = !mem_ready;
                h_addr  = mem_addr;
                h_wdata = mem_wdata;
                h_strb  = mem_strb;
            end else begin
                if (prev_stall) chk("hold_valid", 32'(mem_valid), 32'd1);
                prev_stall = 1'b0;
            end
            if (done) begin
                chk("done_expected", (exp_q.size() == 0) ? 32'd99 : 32'(exp_q[0].kind), 32'(K_DONE));
                if (exp_q.size() != 0 && exp_q[0].kind == K_DONE) begin
                    e = exp_q.pop_front();
                    if (e.cyc >= 0) chk("done_cycle", 32'(cyc), 32'(e.cyc));
                    chk("ready_in_done", 32'(req_ready), 32'd1);
                end
            end
            if (err) begin
                chk("err_expected", (exp_q.size() == 0) ? 32'd99 : 32'(exp_q[0].kind), 32'(K_ERR));
                chk("err_no_beat", 32'(mem_valid), 32'd0);
                if (exp_q.size() != 0 && exp_q[0].kind == K_ERR) begin
                    e = exp_q.pop_front();
                    chk("err_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int nv;
        int nd;
        int ne;
        logic [31:0] cap_addr;
        logic [3:0]  cap_strb;
        logic [31:0] a;
        logic [2:0]  f3;
        int          n;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_valid", 32'(mem_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_strb", 32'(mem_strb), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", 32'(req_ready), 32'd1);

        // Directed, memory always ready: latency is checked exactly.
        mem_ready = 1'b1;
        issue(32'h0000_1000, 32'hDEAD_BEEF, F3_SW, 1'b1);
        issue(32'h0000_1003, 32'h0000_00A5, F3_SB, 1'b1);
        issue(32'h0000_2003, 32'h0000_1234, F3_SH, 1'b1);
        issue(32'hFFFF_FFFE, 32'hAABB_CCDD, F3_SW, 1'b1);
        issue(32'h0000_4000, 32'h5555_5555, 3'b011, 1'b1);
        issue(32'h0000_4001, 32'hFFFF_FF77, F3_SB, 1'b1);

        // Split store with beat0 stalled for three cycles.
        n = 0;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        mem_ready = 1'b0;
        issue(32'h0000_3002, 32'h1122_3344, F3_SW, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        mem_ready = 1'b1;

        // Reset while the second beat is pending.
        issue(32'h0000_5001, 32'h0102_0304, F3_SW, 1'b0);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(mem_valid), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_ready_after", 32'(req_ready), 32'd1);

        // Random stores with random memory back-pressure.
        ready_rand = 1'b1;
        for (int i = 0; i < 150; i++) begin
            a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF8 + 32'($urandom_range(0, 7))) : $urandom;
            f3 = ($urandom_range(0, 7) < 7) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
            issue(a, $urandom, f3, 1'b0);
        end
        ready_rand = 1'b0;
        #2;
        mem_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
        chk("drain", 32'(exp_q.size()), 32'd0);

        // Non-splitting instance: crossing store is rejected, aligned store passes.
        ns_req_valid = 1'b1;
        ns_req_addr  = 32'h0000_1001;
        ns_req_data  = 32'hCAFE_F00D;
        ns_req_f3    = F3_SW;
        @(posedge clk); #1;
        ns_req_valid = 1'b0;
        nv = 0; nd = 0; ne = 0;
        repeat (4) begin
            @(negedge clk);
            nv += int'(ns_mem_valid);
            nd += int'(ns_done);
            ne += int'(ns_err);
        end
        chk("ns_cross_err", 32'(ne), 32'd1);
        chk("ns_cross_nobeat", 32'(nv), 32'd0);
        chk("ns_cross_nodone", 32'(nd), 32'd0);

        @(posedge clk); #1;
        ns_req_valid = 1'b1;
        ns_req_addr  = 32'h0000_1006;
        ns_req_data  = 32'h0000_BEEF;
        ns_req_f3    = F3_SH;
        @(posedge clk); #1;
        ns_req_valid = 1'b0;
        nv = 0; nd = 0; ne = 0;
        cap_addr = '0;
        cap_strb = '0;
        repeat (4) begin
            @(negedge clk);
            if (ns_mem_valid) begin
                cap_addr = ns_mem_addr;
                cap_strb = ns_mem_strb;
                chk("ns_wdata", ns_mem_wdata, 32'hBEEF_0000);
            end
            nv += int'(ns_mem_valid);
            nd += int'(ns_done);
            ne += int'(ns_err);
        end
        chk("ns_aligned_beats", 32'(nv), 32'd1);
        chk("ns_aligned_done", 32'(nd), 32'd1);
        chk("ns_aligned_noerr", 32'(ne), 32'd0);
        chk("ns_addr", cap_addr, 32'h0000_1004);
        chk("ns_strb", 32'(cap_strb), 32'hC);

        @(posedge clk); #1;
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
